// File: rtl/id_ex_register_pkg.sv
// id_ex_register_pkg: shared widths, ALU opcode encodings and control bundle for the ID/EX stage
package id_ex_register_pkg;

    localparam int DefRegWidth = 16;
    localparam int DefAddrBits = 3;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3,
        AluXor = 4'd4,
        AluSlt = 4'd5,
        AluSll = 4'd6,
        AluSrl = 4'd7
    } aluOpType;

    typedef struct packed {
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic aluSrc;
    } ctrlBundle;

    localparam ctrlBundle CtrlNone = '0;

endpackage

// File: rtl/id_ex_register_hazard_detect.sv
// hazard_detect: load-use hazard detection and the resulting front-end stall request
module hazard_detect #(
    parameter int AddrBits = 3
) (
    input  logic                exValid,
    input  logic                exMemRead,
    input  logic [AddrBits-1:0] exDest,
    input  logic                idValid,
    input  logic [AddrBits-1:0] readAddr1,
    input  logic [AddrBits-1:0] readAddr2,
    input  logic                uses1,
    input  logic                uses2,
    input  logic                flushEx,
    output logic                loadUse,
    output logic                hazardStall
);

    assign loadUse = exValid & exMemRead & idValid &
                     ((uses1 & (readAddr1 == exDest)) | (uses2 & (readAddr2 == exDest)));
    assign hazardStall = loadUse & ~flushEx;

endmodule

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with load-use stall, WB bypass and bubble counting
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int RegWidth = DefRegWidth,
    parameter int AddrBits = DefAddrBits
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ID_Valid,
    input  logic [AddrBits-1:0] ReadAddr1,
    input  logic [AddrBits-1:0] ReadAddr2,
    input  logic                Uses1,
    input  logic                Uses2,
    input  logic [RegWidth-1:0] ReadData1,
    input  logic [RegWidth-1:0] ReadData2,
    input  logic [AddrBits-1:0] DestAddr,
    input  logic [RegWidth-1:0] Imm,
    input  logic [3:0]          ALUOp,
    input  logic                RegWrite,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                MemToReg,
    input  logic                ALUSrc,
    input  logic                WB_WriteEN,
    input  logic [AddrBits-1:0] WB_WriteAddr,
    input  logic [RegWidth-1:0] WB_WriteData,
    input  logic                FlushEX,
    output logic                HazardStall,
    output logic                EX_Valid,
    output logic [RegWidth-1:0] EX_A,
    output logic [RegWidth-1:0] EX_B,
    output logic [RegWidth-1:0] EX_Imm,
    output logic [AddrBits-1:0] EX_Dest,
    output logic [3:0]          EX_ALUOp,
    output logic                EX_RegWrite,
    output logic                EX_MemRead,
    output logic                EX_MemWrite,
    output logic                EX_MemToReg,
    output logic                EX_ALUSrc,
    output logic [15:0]         BubbleCount
);

    ctrlBundle idCtrl, exCtrl;
    logic loadUse, advance, bubble;
    logic [RegWidth-1:0] bypassA, bypassB;

    assign idCtrl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc};
    assign {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc} = exCtrl;

    // a write-back in flight this cycle is newer than the register-file read
    assign bypassA = (WB_WriteEN && WB_WriteAddr == ReadAddr1) ? WB_WriteData : ReadData1;
    assign bypassB = (WB_WriteEN && WB_WriteAddr == ReadAddr2) ? WB_WriteData : ReadData2;

    assign advance = ~(FlushEX | loadUse);
    assign bubble  = ID_Valid & ~advance;

    hazard_detect #(.AddrBits(AddrBits)) hazardDetect (
        .exValid    (EX_Valid),
        .exMemRead  (EX_MemRead),
        .exDest     (EX_Dest),
        .idValid    (ID_Valid),
        .readAddr1  (ReadAddr1),
        .readAddr2  (ReadAddr2),
        .uses1      (Uses1),
        .uses2      (Uses2),
        .flushEx    (FlushEX),
        .loadUse    (loadUse),
        .hazardStall(HazardStall)
    );

    // valid and control bits: cleared whenever a bubble goes in or ID is empty
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EX_Valid <= 1'b0;
            exCtrl   <= CtrlNone;
        end else begin
            EX_Valid <= advance & ID_Valid;
            exCtrl   <= (advance & ID_Valid) ? idCtrl : CtrlNone;
        end
    end

    // data fields follow ID on a normal cycle and simply hold under a bubble
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EX_A     <= '0;
            EX_B     <= '0;
            EX_Imm   <= '0;
            EX_Dest  <= '0;
            EX_ALUOp <= '0;
        end else if (advance) begin
            EX_A     <= bypassA;
            EX_B     <= bypassB;
            EX_Imm   <= Imm;
            EX_Dest  <= DestAddr;
            EX_ALUOp <= ALUOp;
        end
    end

    // saturating count of bubbles that displaced a real ID instruction
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) BubbleCount <= '0;
        else if (bubble && BubbleCount != 16'hFFFF) BubbleCount <= BubbleCount + 16'd1;
    end

endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: scoreboard bench with a rule-level reference model of the ID/EX stage
module tb_id_ex_register;

    localparam int W = 16;
    localparam int A = 3;

    logic CLK = 1'b0;
    logic RST;
    logic ID_Valid, Uses1, Uses2;
    logic [A-1:0] ReadAddr1, ReadAddr2, DestAddr, WB_WriteAddr;
    logic [W-1:0] ReadData1, ReadData2, Imm, WB_WriteData;
    logic [3:0] ALUOp;
    logic RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, WB_WriteEN, FlushEX;
    logic HazardStall, EX_Valid;
    logic [W-1:0] EX_A, EX_B, EX_Imm;
    logic [A-1:0] EX_Dest;
    logic [3:0] EX_ALUOp;
    logic EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc;
    logic [15:0] BubbleCount;

    id_ex_register #(.RegWidth(W), .AddrBits(A)) dut (
        .CLK(CLK), .RST(RST), .ID_Valid(ID_Valid),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .Uses1(Uses1), .Uses2(Uses2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .DestAddr(DestAddr), .Imm(Imm),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .ALUSrc(ALUSrc), .WB_WriteEN(WB_WriteEN),
        .WB_WriteAddr(WB_WriteAddr), .WB_WriteData(WB_WriteData), .FlushEX(FlushEX),
        .HazardStall(HazardStall), .EX_Valid(EX_Valid), .EX_A(EX_A), .EX_B(EX_B),
        .EX_Imm(EX_Imm), .EX_Dest(EX_Dest), .EX_ALUOp(EX_ALUOp),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemToReg(EX_MemToReg), .EX_ALUSrc(EX_ALUSrc), .BubbleCount(BubbleCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit v;
        logic [W-1:0] a, b, imm;
        logic [A-1:0] dest;
        logic [3:0] op;
        logic [4:0] ctrl;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int passCnt = 0;
    int totalCnt = 0;

    // reference model state: what the EX stage should currently hold
    bit mValid, mMemRead;
    logic [A-1:0] mDest;
    int mCnt;

    wire [4:0] exCtrlBits = {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    task automatic modelReset();
        mValid = 0; mMemRead = 0; mDest = '0; mCnt = 0;
    endtask

    task automatic clearInputs();
        ID_Valid = 0; Uses1 = 0; Uses2 = 0; ReadAddr1 = '0; ReadAddr2 = '0; DestAddr = '0;
        ReadData1 = '0; ReadData2 = '0; Imm = '0; ALUOp = '0;
        RegWrite = 0; MemRead = 0; MemWrite = 0; MemToReg = 0; ALUSrc = 0;
        WB_WriteEN = 0; WB_WriteAddr = '0; WB_WriteData = '0; FlushEX = 0;
    endtask

    task automatic randInputs();
        ID_Valid = ($urandom_range(0, 9) != 0);
        Uses1 = 1'($urandom); Uses2 = 1'($urandom);
        ReadAddr1 = A'($urandom); ReadAddr2 = A'($urandom); DestAddr = A'($urandom);
        ReadData1 = W'($urandom); ReadData2 = W'($urandom); Imm = W'($urandom);
        ALUOp = 4'($urandom);
        RegWrite = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
        MemToReg = 1'($urandom); ALUSrc = 1'($urandom);
        WB_WriteEN = 1'($urandom); WB_WriteAddr = A'($urandom); WB_WriteData = W'($urandom);
        FlushEX = ($urandom_range(0, 9) == 0);
    endtask

    // apply the stage rules to the current ID inputs, check the stall, queue the EX result
    task automatic step();
        bit hz;
        exp_t e;
        #1;
        hz = mValid && mMemRead && ID_Valid &&
             ((Uses1 && ReadAddr1 == mDest) || (Uses2 && ReadAddr2 == mDest));
        chk("HazardStall", 32'(HazardStall), 32'(hz && !FlushEX));
        if (ID_Valid && (hz || FlushEX) && mCnt < 65535) mCnt++;
        e = '{default: '0};
        if (hz || FlushEX || !ID_Valid) begin
            mValid = 0; mMemRead = 0;
        end else begin
            mValid = 1; mMemRead = MemRead; mDest = DestAddr;
            e.v = 1;
            e.a = (WB_WriteEN && WB_WriteAddr == ReadAddr1) ? WB_WriteData : ReadData1;
            e.b = (WB_WriteEN && WB_WriteAddr == ReadAddr2) ? WB_WriteData : ReadData2;
            e.imm = Imm; e.dest = DestAddr; e.op = ALUOp;
            e.ctrl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc};
        end
        e.cnt = 16'(mCnt);
        q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic issueLoad(input logic [A-1:0] dst);
        clearInputs();
        ID_Valid = 1; MemRead = 1; MemToReg = 1; RegWrite = 1; DestAddr = dst;
        step();
    endtask

    // monitor: compare every registered EX result against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST && q.size() > 0) begin
                e = q.pop_front();
                chk("EX_Valid", 32'(EX_Valid), 32'(e.v));
                chk("EX_ctrl", 32'(exCtrlBits), 32'(e.ctrl));
                chk("BubbleCount", 32'(BubbleCount), 32'(e.cnt));
                if (e.v) begin
                    chk("EX_A", 32'(EX_A), 32'(e.a));
                    chk("EX_B", 32'(EX_B), 32'(e.b));
                    chk("EX_Imm", 32'(EX_Imm), 32'(e.imm));
                    chk("EX_Dest", 32'(EX_Dest), 32'(e.dest));
                    chk("EX_ALUOp", 32'(EX_ALUOp), 32'(e.op));
                end
            end
        end
    end

    initial begin
        int cntBefore;
        RST = 1;
        randInputs();
        ID_Valid = 1; ReadData1 = 16'h1234; Imm = 16'h5678; RegWrite = 1; MemRead = 1;
        modelReset();
        repeat (2) @(negedge CLK);
        #2;
        chk("rst_EX_Valid", 32'(EX_Valid), 0);
        chk("rst_EX_A", 32'(EX_A), 0);
        chk("rst_EX_B", 32'(EX_B), 0);
        chk("rst_EX_Imm", 32'(EX_Imm), 0);
        chk("rst_EX_Dest", 32'(EX_Dest), 0);
        chk("rst_EX_ALUOp", 32'(EX_ALUOp), 0);
        chk("rst_ctrl", 32'(exCtrlBits), 0);
        chk("rst_BubbleCount", 32'(BubbleCount), 0);
        chk("rst_HazardStall", 32'(HazardStall), 0);
        @(negedge CLK);
        RST = 0;

        clearInputs();
        ID_Valid = 1; ReadData1 = 16'd25; ReadData2 = 16'd99; DestAddr = 3'd3; RegWrite = 1;
        step();
        chk("pass_EX_A", 32'(EX_A), 25);
        chk("pass_EX_B", 32'(EX_B), 99);
        chk("pass_EX_Dest", 32'(EX_Dest), 3);
        chk("pass_EX_Valid", 32'(EX_Valid), 1);

        issueLoad(3'd2);
        clearInputs();
        ID_Valid = 1; ReadAddr1 = 3'd2; Uses1 = 1; DestAddr = 3'd5; RegWrite = 1;
        #1 chk("lu_HazardStall", 32'(HazardStall), 1);
        step();
        chk("lu_bubble_valid", 32'(EX_Valid), 0);
        chk("lu_BubbleCount", 32'(BubbleCount), 1);
        step();
        chk("lu_enter_valid", 32'(EX_Valid), 1);
        chk("lu_enter_dest", 32'(EX_Dest), 5);

        issueLoad(3'd2);
        clearInputs();
        ID_Valid = 1; ReadAddr1 = 3'd2; Uses1 = 0; DestAddr = 3'd4;
        #1 chk("nofalse_HazardStall", 32'(HazardStall), 0);
        step();
        chk("nofalse_valid", 32'(EX_Valid), 1);

        clearInputs();
        ID_Valid = 1; WB_WriteEN = 1; WB_WriteAddr = 3'd3; WB_WriteData = -16'sd40;
        ReadAddr2 = 3'd3; ReadData2 = '0;
        step();
        chk("bypass_EX_B", 32'(EX_B), 32'h0000FFD8);

        issueLoad(3'd2);
        cntBefore = int'(BubbleCount);
        clearInputs();
        ID_Valid = 1; ReadAddr1 = 3'd2; Uses1 = 1; FlushEX = 1; RegWrite = 1;
        #1 chk("flush_HazardStall", 32'(HazardStall), 0);
        step();
        chk("flush_valid", 32'(EX_Valid), 0);
        chk("flush_BubbleCount", 32'(BubbleCount), 32'(cntBefore + 1));

        issueLoad(3'd6);
        clearInputs();
        ID_Valid = 1; ReadAddr2 = 3'd6; Uses2 = 1;
        #1 chk("midrst_stall_before", 32'(HazardStall), 1);
        #1 RST = 1;
        #1;
        chk("midrst_HazardStall", 32'(HazardStall), 0);
        chk("midrst_EX_Valid", 32'(EX_Valid), 0);
        chk("midrst_BubbleCount", 32'(BubbleCount), 0);
        q.delete();
        modelReset();
        @(negedge CLK);
        RST = 0;
        step();

        for (int i = 0; i < 3000; i++) begin
            randInputs();
            step();
        end
        clearInputs();
        step();
        chk("scoreboard_drained", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
